// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: fetch/decode/exec/mem/wb sequencing with strobes for PC, register file and memories.
// Optional illegal-opcode trap state and port are enabled by defining CFG_ILLEGAL_TRAP_EN.
`ifndef CFG_INST_DATA_WIDTH
`define CFG_INST_DATA_WIDTH 32
`endif

module riscv_multicycle_ctrl #(
    parameter int INST_DATA_WIDTH = `CFG_INST_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    input  logic                       imem_ack,
    input  logic [INST_DATA_WIDTH-1:0] imem_rdata,
    output logic [INST_DATA_WIDTH-1:0] ir,
    input  logic                       branch_taken,
    output logic                       dmem_req,
    output logic                       dmem_we,
    input  logic                       dmem_ack,
    output logic                       rf_we,
    output logic [1:0]                 wb_sel,
    output logic                       pc_en,
    output logic [1:0]                 pc_sel,
    output logic [2:0]                 state
`ifdef CFG_ILLEGAL_TRAP_EN
    ,
    output logic                       illegal
`endif
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
`ifdef CFG_ILLEGAL_TRAP_EN
        ,
        S_TRAP   = 3'd6
`endif
    } state_t;

    state_t     cur;
    logic [4:0] opc;
    logic       legal;
    logic       is_mem;
    logic       is_nop;
    logic       is_branch;

    assign state = cur;
    assign opc   = ir[6:2];

    always_comb begin
        legal = 1'b0;
        if (ir[1:0] == 2'b11) begin
            case (opc)
                OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM,
                OP_OP, OP_BRANCH, OP_STORE, OP_SYSTEM, OP_FENCE: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end
    end

    assign is_mem    = legal && (opc == OP_LOAD || opc == OP_STORE);
    assign is_nop    = legal && (opc == OP_FENCE || opc == OP_SYSTEM);
    assign is_branch = legal && (opc == OP_BRANCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= S_IDLE;
            ir  <= '0;
        end else begin
            case (cur)
                S_IDLE:   cur <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        ir  <= imem_rdata;
                        cur <= S_DECODE;
                    end
                end
                S_DECODE: cur <= S_EXEC;
                S_EXEC: begin
                    if (!legal) begin
`ifdef CFG_ILLEGAL_TRAP_EN
                        cur <= S_TRAP;
`else
                        cur <= S_FETCH;
`endif
                    end else if (is_mem) begin
                        cur <= S_MEM;
                    end else if (is_branch || is_nop) begin
                        cur <= S_FETCH;
                    end else begin
                        cur <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) cur <= (opc == OP_LOAD) ? S_WB : S_FETCH;
                end
                S_WB:     cur <= S_FETCH;
`ifdef CFG_ILLEGAL_TRAP_EN
                S_TRAP:   cur <= S_FETCH;
`endif
                default:  cur <= S_IDLE;
            endcase
        end
    end

    // Strobes decode from the registered state so they line up with the
    // branch_taken/dmem_ack inputs of the same cycle; reset clears them via cur.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 2'b00;
        pc_en    = 1'b0;
        pc_sel   = 2'b00;
`ifdef CFG_ILLEGAL_TRAP_EN
        illegal  = 1'b0;
`endif
        case (cur)
            S_FETCH: imem_req = 1'b1;
            S_EXEC: begin
                if (!legal) begin
`ifndef CFG_ILLEGAL_TRAP_EN
                    pc_en = 1'b1;
`endif
                end else if (is_branch) begin
                    pc_en  = 1'b1;
                    pc_sel = branch_taken ? 2'b01 : 2'b00;
                end else if (is_nop) begin
                    pc_en = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opc == OP_STORE);
                pc_en    = dmem_ack && (opc == OP_STORE);
            end
            S_WB: begin
                rf_we = 1'b1;
                pc_en = 1'b1;
                case (opc)
                    OP_LUI:  wb_sel = 2'b11;
                    OP_LOAD: wb_sel = 2'b01;
                    OP_JAL: begin
                        wb_sel = 2'b10;
                        pc_sel = 2'b01;
                    end
                    OP_JALR: begin
                        wb_sel = 2'b10;
                        pc_sel = 2'b10;
                    end
                    default: wb_sel = 2'b00;
                endcase
            end
`ifdef CFG_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal = 1'b1;
                pc_en   = 1'b1;
                pc_sel  = 2'b11;
            end
`endif
            default: ;
        endcase
    end

endmodule
